// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, read-latency bounds.
// Latency: n/a (types only). Backpressure: n/a.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin tie-break between CPU (req[0]) and host (req[1]).
// Latency: combinational. Backpressure: none, caller decides when the grant is used.
module rr_arbiter_2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     grant
);

    always_comb begin
        grant = OWN_CPU;
        if (req == 2'b11) begin
            grant = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
        end else if (req[1]) begin
            grant = OWN_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and host load/store requests onto one data-memory port, one transaction at a time.
// Latency: ack N+1+L after the IDLE cycle a request is seen (L=1 write, MEM_LAT read).
// Backpressure: requesters hold their request until ack; cpu_stall flags the wait.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic              busy
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_range
        $error("dmem_arbiter: MEM_LAT must be within 1..4");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    owner_t             r_owner;
    owner_t             r_last_owner;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_host_rdata;

    owner_t             w_grant;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_latch;
    logic               w_capture;
    logic               w_last;

    rr_arbiter_2 u_rr (
        .req        ({host_req, cpu_req}),
        .last_owner (r_last_owner),
        .grant      (w_grant)
    );

    assign w_sel_we    = (w_grant == OWN_HOST) ? host_we    : cpu_we;
    assign w_sel_addr  = (w_grant == OWN_HOST) ? host_addr  : cpu_addr;
    assign w_sel_wdata = (w_grant == OWN_HOST) ? host_wdata : cpu_wdata;

    // Writes finish in one ACCESS cycle; reads wait out the memory latency.
    assign w_last = r_we || (r_cnt == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        cpu_ack     = 1'b0;
        host_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req || host_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = !r_we;
                mem_write = r_we;
                if (w_last) begin
                    w_capture   = !r_we;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                cpu_ack     = (r_owner == OWN_CPU);
                host_ack    = (r_owner == OWN_HOST);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_HOST;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_owner <= w_grant;
                r_cnt   <= '0;
            end else if (r_state == ACCESS && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                if (r_owner == OWN_CPU) begin
                    r_cpu_rdata <= mem_data_out;
                end else begin
                    r_host_rdata <= mem_data_out;
                end
            end
            if (r_state == RESP) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;
    assign cpu_rdata   = r_cpu_rdata;
    assign host_rdata  = r_host_rdata;
    assign cpu_stall   = cpu_req && !cpu_ack;
    assign busy        = (r_state != IDLE);

endmodule
